// File: rtl/rsa_modexp_core.sv
// Modular exponentiation core: ciphertext = plaintext^exp_e mod mod_m using left-to-right
// square-and-multiply over a bit-serial interleaved multiplier. Define RSA_CONST_TIME_EN for fixed-latency operation.
module rsa_modexp_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             en_rsa,
    input  logic             clear_rsa,
    input  logic [WIDTH-1:0] plaintext,
    input  logic [WIDTH-1:0] exp_e,
    input  logic [WIDTH-1:0] mod_m,
    output logic [WIDTH-1:0] ciphertext,
    output logic             eoc_rsa,
    output logic             err,
    output logic             busy,
    output logic [2:0]       dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SQR  = 3'd2,
        S_MUL  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Handshake: clear_rsa low holds the core in IDLE; a clear_rsa 0->1 edge with en_rsa=1
    // starts one operation; eoc_rsa then stays high until clear_rsa is taken low again.
    state_t            state, state_next;
    logic [WIDTH-1:0]  r_q, p_q, e_q, m_q;
    logic [WIDTH+1:0]  acc_q;
    logic [CW-1:0]     j_q, i_q;
    logic              err_q;
    logic              clear_seen;

    logic              start;
    logic              load_err;
    logic              last_iter;
    logic              e_bit;
    logic [WIDTH-1:0]  mul_b;
    logic [WIDTH+1:0]  m_ext, t0, t1, t2;

    assign start     = clear_seen && clear_rsa && en_rsa;
    assign load_err  = (mod_m == '0) || (plaintext >= mod_m);
    assign last_iter = (j_q == '0);
    assign e_bit     = e_q[i_q];

    // One interleaved step: acc = 2*acc + A[j]*B, then at most two subtractions of M.
    always_comb begin
        mul_b = (state == S_MUL) ? p_q : r_q;
        m_ext = {2'b00, m_q};
        t0    = (acc_q << 1) + (r_q[j_q] ? {2'b00, mul_b} : '0);
        t1    = (t0 >= m_ext) ? (t0 - m_ext) : t0;
        t2    = (t1 >= m_ext) ? (t1 - m_ext) : t1;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_LOAD;
            S_LOAD: state_next = load_err ? S_DONE : S_SQR;
            S_SQR: begin
                if (last_iter) begin
`ifdef RSA_CONST_TIME_EN
                    state_next = S_MUL;
`else
                    if (e_bit)           state_next = S_MUL;
                    else if (i_q == '0)  state_next = S_DONE;
                    else                 state_next = S_SQR;
`endif
                end
            end
            S_MUL: begin
                if (last_iter) state_next = (i_q == '0) ? S_DONE : S_SQR;
            end
            S_DONE: state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            r_q        <= '0;
            p_q        <= '0;
            e_q        <= '0;
            m_q        <= '0;
            acc_q      <= '0;
            j_q        <= '0;
            i_q        <= '0;
            err_q      <= 1'b0;
            clear_seen <= 1'b0;
            ciphertext <= '0;
            err        <= 1'b0;
            eoc_rsa    <= 1'b0;
        end else if (!ena) begin
            state <= state;
        end else if (!clear_rsa) begin
            // ciphertext/err survive the clear so the register bank can still read them
            state      <= S_IDLE;
            eoc_rsa    <= 1'b0;
            clear_seen <= 1'b1;
        end else if (en_rsa) begin
            clear_seen <= 1'b0;
            state      <= state_next;
            case (state)
                S_LOAD: begin
                    p_q   <= plaintext;
                    e_q   <= exp_e;
                    m_q   <= mod_m;
                    acc_q <= '0;
                    j_q   <= CW'(WIDTH - 1);
                    i_q   <= CW'(WIDTH - 1);
                    err_q <= load_err;
                    if (load_err)               r_q <= '0;
                    else if (mod_m == WIDTH'(1)) r_q <= '0;
                    else                        r_q <= WIDTH'(1);
                end
                S_SQR, S_MUL: begin
                    if (!last_iter) begin
                        acc_q <= t2;
                        j_q   <= j_q - CW'(1);
                    end else begin
                        acc_q <= '0;
                        j_q   <= CW'(WIDTH - 1);
`ifdef RSA_CONST_TIME_EN
                        // the dummy multiply for a zero exponent bit is computed but dropped
                        if (state == S_SQR || e_bit) r_q <= t2[WIDTH-1:0];
`else
                        r_q <= t2[WIDTH-1:0];
`endif
                        if (state_next == S_SQR) i_q <= i_q - CW'(1);
                    end
                end
                S_DONE: begin
                    ciphertext <= r_q;
                    err        <= err_q;
                    eoc_rsa    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy      = (state == S_LOAD) || (state == S_SQR) || (state == S_MUL);
        dbg_state = state;
    end

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Directed bench for rsa_modexp_core: hand-computed RSA vectors, boundaries, abort, freeze and reset.
// Latency expectations follow RSA_CONST_TIME_EN when it is defined for the build.
module tb_rsa_modexp_core;

    localparam int W = 8;
`ifdef RSA_CONST_TIME_EN
    localparam bit CONST_TIME = 1'b1;
`else
    localparam bit CONST_TIME = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         ena;
    logic         en_rsa;
    logic         clear_rsa;
    logic [W-1:0] plaintext;
    logic [W-1:0] exp_e;
    logic [W-1:0] mod_m;
    logic [W-1:0] ciphertext;
    logic         eoc_rsa;
    logic         err;
    logic         busy;
    logic [2:0]   dbg_state;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];
    int           lat;

    rsa_modexp_core #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .en_rsa     (en_rsa),
        .clear_rsa  (clear_rsa),
        .plaintext  (plaintext),
        .exp_e      (exp_e),
        .mod_m      (mod_m),
        .ciphertext (ciphertext),
        .eoc_rsa    (eoc_rsa),
        .err        (err),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Edges from start edge to eoc: 2 + W*W squarings + W per set exponent bit.
    function automatic int exp_lat(input int pop);
        if (CONST_TIME) return 2 + 2 * W * W;
        return 2 + W * W + W * pop;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // driver: clear pulse then the start edge; on return the start edge (edge 0) has passed
    task automatic start_op(input logic [W-1:0] p, input logic [W-1:0] e,
                            input logic [W-1:0] m, input logic [W-1:0] exp_ct);
        plaintext = p;
        exp_e     = e;
        mod_m     = m;
        en_rsa    = 1'b1;
        clear_rsa = 1'b0;
        step();
        clear_rsa = 1'b1;
        step();
        exp_q.push_back(exp_ct);
    endtask

    task automatic wait_eoc(input int from, output int n_out);
        n_out = -1;
        for (int n = from + 1; n <= from + 400; n++) begin
            step();
            if (eoc_rsa) begin
                n_out = n;
                break;
            end
        end
    endtask

    task automatic finish_op(input string tag, input int from, input logic exp_err, input int lat_exp);
        logic [W-1:0] exp_ct;
        int           n;
        wait_eoc(from, n);
        exp_ct = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check_eq({tag, "_lat"}, n, lat_exp);
        check_eq({tag, "_ct"}, ciphertext, exp_ct);
        check_eq({tag, "_err"}, err, exp_err);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] p, input logic [W-1:0] e,
                          input logic [W-1:0] m, input logic [W-1:0] exp_ct,
                          input logic exp_err, input int lat_exp);
        start_op(p, e, m, exp_ct);
        finish_op(tag, 0, exp_err, lat_exp);
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; en_rsa = 1'b0; clear_rsa = 1'b1;
        plaintext = '0; exp_e = '0; mod_m = '0;
        step();
        step();
        check_eq("rst_ct", ciphertext, 0);
        check_eq("rst_eoc", eoc_rsa, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_state", dbg_state, 0);
        rst = 1'b0;
        step();

        // 9^7 mod 143 = 48, E has 3 set bits
        run_op("enc", 8'd9, 8'd7, 8'd143, 8'd48, 1'b0, exp_lat(3));
        repeat (3) step();
        check_eq("enc_hold_eoc", eoc_rsa, 1);
        check_eq("enc_hold_busy", busy, 0);
        check_eq("enc_hold_ct", ciphertext, 48);

        // 48^103 mod 143 = 9, E=0b01100111 has 5 set bits
        run_op("dec", 8'd48, 8'd103, 8'd143, 8'd9, 1'b0, exp_lat(5));
        clear_rsa = 1'b0;
        step();
        check_eq("dec_clr_eoc", eoc_rsa, 0);
        check_eq("dec_clr_ct", ciphertext, 9);
        check_eq("dec_clr_state", dbg_state, 0);

        run_op("e_zero", 8'd5, 8'd0, 8'd143, 8'd1, 1'b0, exp_lat(0));
        run_op("m_one", 8'd0, 8'd7, 8'd1, 8'd0, 1'b0, exp_lat(3));
        run_op("m_zero", 8'd5, 8'd7, 8'd0, 8'd0, 1'b1, 2);
        run_op("p_big", 8'd200, 8'd7, 8'd143, 8'd0, 1'b1, 2);
        run_op("p_eq_m", 8'd143, 8'd7, 8'd143, 8'd0, 1'b1, 2);

        // abort at edge 30: ciphertext must stay at the previous result (1)
        run_op("pre_abort", 8'd5, 8'd0, 8'd143, 8'd1, 1'b0, exp_lat(0));
        start_op(8'd9, 8'd7, 8'd143, 8'd48);
        repeat (29) step();
        check_eq("abort_busy_before", busy, 1);
        clear_rsa = 1'b0;
        step();
        exp_q.delete();
        check_eq("abort_busy", busy, 0);
        check_eq("abort_eoc", eoc_rsa, 0);
        check_eq("abort_ct", ciphertext, 1);
        check_eq("abort_state", dbg_state, 0);
        repeat (5) step();
        check_eq("abort_no_eoc", eoc_rsa, 0);

        // restart; operands scrambled after the LOAD edge must not matter
        start_op(8'd9, 8'd7, 8'd143, 8'd48);
        step();
        plaintext = 8'd1; exp_e = 8'd0; mod_m = 8'd0;
        finish_op("restart", 1, 1'b0, exp_lat(3));

        // en_rsa low for 10 edges during the first squaring pass
        run_op("pre_frz", 8'd5, 8'd0, 8'd143, 8'd1, 1'b0, exp_lat(0));
        start_op(8'd9, 8'd7, 8'd143, 8'd48);
        repeat (19) step();
        en_rsa = 1'b0;
        repeat (10) step();
        check_eq("frz_busy", busy, 1);
        en_rsa = 1'b1;
        finish_op("frz_en", 29, 1'b0, exp_lat(3) + 10);

        // ena low for 10 edges; a clear pulse inside the freeze must be ignored
        start_op(8'd48, 8'd103, 8'd143, 8'd9);
        repeat (19) step();
        ena = 1'b0;
        repeat (4) step();
        clear_rsa = 1'b0;
        repeat (2) step();
        clear_rsa = 1'b1;
        repeat (4) step();
        check_eq("frz_ena_eoc", eoc_rsa, 0);
        ena = 1'b1;
        finish_op("frz_ena", 29, 1'b0, exp_lat(5) + 10);

        // reset at edge 40 clears everything, then a normal run
        start_op(8'd9, 8'd7, 8'd143, 8'd48);
        repeat (39) step();
        rst = 1'b1;
        step();
        exp_q.delete();
        check_eq("mrst_ct", ciphertext, 0);
        check_eq("mrst_eoc", eoc_rsa, 0);
        check_eq("mrst_err", err, 0);
        check_eq("mrst_busy", busy, 0);
        check_eq("mrst_state", dbg_state, 0);
        rst = 1'b0;
        step();
        run_op("post_rst", 8'd9, 8'd7, 8'd143, 8'd48, 1'b0, exp_lat(3));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
